// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter and the pipeline-side request logic.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D
  } arb_owner_t;

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// Fetch port, data port and unified-memory port bundled together.
// master = pipeline stages plus memory, slave = the arbiter sitting between them.
interface imem_dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_dmem_arbiter_perf_counters.sv
// Free-running 32-bit grant and conflict counters, wrapping modulo 2^32.
module arb_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_grant_i,
  input  logic        d_grant_i,
  input  logic        conflict_i,
  output logic [31:0] perf_if_grants_o,
  output logic [31:0] perf_d_grants_o,
  output logic [31:0] perf_conflicts_o
);

  logic [31:0] if_grants_q;
  logic [31:0] d_grants_q;
  logic [31:0] conflicts_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      if_grants_q <= '0;
      d_grants_q  <= '0;
      conflicts_q <= '0;
    end else begin
      if (if_grant_i) if_grants_q <= if_grants_q + 32'd1;
      if (d_grant_i)  d_grants_q  <= d_grants_q + 32'd1;
      if (conflict_i) conflicts_q <= conflicts_q + 32'd1;
    end
  end

  assign perf_if_grants_o = if_grants_q;
  assign perf_d_grants_o  = d_grants_q;
  assign perf_conflicts_o = conflicts_q;

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Single-outstanding arbiter sharing one memory between fetch and load/store; data wins unless
// fetch has waited MAX_DATA_STREAK data grants. ARB_PERF_CNT_EN adds grant/conflict counters.
module imem_dmem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic               clk,
  input  logic               rst,
  imem_dmem_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]        perf_if_grants,
  output logic [31:0]        perf_d_grants,
  output logic [31:0]        perf_conflicts
`endif
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  arb_owner_t        sel;
  logic [SW-1:0]     streak_q, streak_d;
  logic              we_q, we_d;
  logic              fetch_first;
  logic              req_live;
  logic              grant;
  logic              rsp;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  // In REQ the latched owner keeps the bus even if the other port now has priority.
  always_comb begin
    fetch_first = bus.if_req && (!bus.d_req || (streak_q == STREAK_MAX));
    sel         = OWN_NONE;
    case (state_q)
      IDLE:    if (bus.if_req || bus.d_req) sel = fetch_first ? OWN_IF : OWN_D;
      REQ:     sel = owner_q;
      default: sel = OWN_NONE;
    endcase
  end

  assign req_live  = !rst && (((sel == OWN_IF) && bus.if_req) || ((sel == OWN_D) && bus.d_req));
  assign grant     = req_live && bus.mem_gnt;
  assign rsp       = !rst && (state_q == WAIT) && bus.mem_rvalid;
  assign addr_sel  = (sel == OWN_IF) ? bus.if_addr : bus.d_addr;
  assign wdata_sel = (req_live && (sel == OWN_D)) ? bus.d_wdata : '0;

  assign bus.mem_req   = req_live;
  assign bus.mem_we    = req_live && (sel == OWN_D) && bus.d_we;
  assign bus.mem_addr  = req_live ? addr_sel : '0;
  assign bus.mem_wdata = wdata_sel;

  assign bus.if_gnt    = grant && (sel == OWN_IF);
  assign bus.d_gnt     = grant && (sel == OWN_D);
  assign bus.if_rvalid = rsp && (owner_q == OWN_IF);
  assign bus.d_rvalid  = rsp && (owner_q == OWN_D);
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
  assign bus.d_rdata   = (bus.d_rvalid && !we_q) ? bus.mem_rdata : '0;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    we_d     = we_q;
    case (state_q)
      IDLE, REQ: begin
        if (req_live) begin
          owner_d = sel;
          we_d    = (sel == OWN_D) && bus.d_we;
          state_d = bus.mem_gnt ? WAIT : REQ;
        end else begin
          owner_d = OWN_NONE;
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          owner_d = OWN_NONE;
          we_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        owner_d = OWN_NONE;
        state_d = IDLE;
      end
    endcase
    // Only data grants made while a fetch is waiting count toward starvation.
    if (grant) begin
      if ((sel == OWN_D) && bus.if_req)
        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
      else
        streak_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_NONE;
      streak_q <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      we_q     <= we_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  arb_perf_counters u_perf (
    .clk              (clk),
    .rst              (rst),
    .if_grant_i       (bus.if_gnt),
    .d_grant_i        (bus.d_gnt),
    .conflict_i       (!rst && (state_q == IDLE) && bus.if_req && bus.d_req),
    .perf_if_grants_o (perf_if_grants),
    .perf_d_grants_o  (perf_d_grants),
    .perf_conflicts_o (perf_conflicts)
  );
`endif

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter with a behavioural memory and a response scoreboard.
module tb_imem_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_grants, perf_d_grants, perf_conflicts;
`endif

  imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_if_grants (perf_if_grants),
    .perf_d_grants  (perf_d_grants),
    .perf_conflicts (perf_conflicts)
`endif
  );

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  logic gnt_log[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, want, $time);
    end
  endtask

  task automatic expect_rsp(input logic is_d, input logic [31:0] data);
    exp_q.push_back('{is_d: is_d, data: data});
  endtask

  // Behavioural memory: grant gated by gnt_en, response rv_gap cycles after the grant cycle.
  logic        gnt_en = 1'b1;
  int          rv_gap = 1;
  logic        spur_rvalid = 1'b0;
  logic [31:0] spur_rdata = 32'h0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  logic [31:0] rsp_q = 32'h0;
  int          m_left = 0;
  logic [31:0] mem_arr [0:63];
  logic [63:0] wr_vld = '0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (wr_vld[a[7:2]]) return mem_arr[a[7:2]];
    case (a)
      32'h10:  return 32'h00500093;
      32'h20:  return 32'h00A00113;
      32'h40:  return 32'h12345678;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rsp_val();
    return bus.mem_we ? 32'hFFFF_FFFF : mem_rd(bus.mem_addr);
  endfunction

  assign bus.mem_gnt    = bus.mem_req && gnt_en;
  assign bus.mem_rvalid = m_rvalid | spur_rvalid;
  assign bus.mem_rdata  = m_rvalid ? m_rdata : (spur_rvalid ? spur_rdata : 32'h0);

  always @(posedge clk) begin
    m_rvalid <= 1'b0;
    if (bus.mem_req && bus.mem_gnt) begin
      if (bus.mem_we) begin
        mem_arr[bus.mem_addr[7:2]] <= bus.mem_wdata;
        wr_vld[bus.mem_addr[7:2]]  <= 1'b1;
      end
      rsp_q  <= rsp_val();
      m_left <= rv_gap - 1;
      if (rv_gap == 1) begin
        m_rvalid <= 1'b1;
        m_rdata  <= rsp_val();
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_rvalid <= 1'b1;
        m_rdata  <= rsp_q;
      end
    end
  end

  // Per-cycle invariants, grant log and scoreboard pop.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      chk("gnt_excl", 64'(bus.if_gnt & bus.d_gnt), 0);
      chk("rvalid_excl", 64'(bus.if_rvalid & bus.d_rvalid), 0);
      if (!bus.if_rvalid) chk("if_rdata_idle", 64'(bus.if_rdata), 0);
      if (!bus.d_rvalid)  chk("d_rdata_idle", 64'(bus.d_rdata), 0);
      if (bus.if_gnt) gnt_log.push_back(1'b0);
      if (bus.d_gnt)  gnt_log.push_back(1'b1);
      if (bus.if_rvalid || bus.d_rvalid) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_rvalid", 64'(1), 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_port", 64'(bus.d_rvalid), 64'(e.is_d));
          chk("sb_data", 64'(bus.d_rvalid ? bus.d_rdata : bus.if_rdata), 64'(e.data));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected < 100000", $time);
    $fatal(1);
  end

  task automatic next();
    @(negedge clk);
  endtask

  task automatic drop_reqs();
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_mem_req"},   64'(bus.mem_req), 0);
    chk({tag, "_mem_we"},    64'(bus.mem_we), 0);
    chk({tag, "_mem_addr"},  64'(bus.mem_addr), 0);
    chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 0);
    chk({tag, "_if_gnt"},    64'(bus.if_gnt), 0);
    chk({tag, "_d_gnt"},     64'(bus.d_gnt), 0);
    chk({tag, "_if_rvalid"}, 64'(bus.if_rvalid), 0);
    chk({tag, "_d_rvalid"},  64'(bus.d_rvalid), 0);
  endtask

  initial begin
    rst = 1'b1;
    drop_reqs();
    next();
    next();
    #1;
    outs_zero("reset");
    rst = 1'b0;

    // Fetch only, response two cycles after the grant.
    next();
    rv_gap = 2;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    expect_rsp(1'b0, 32'h00500093);
    #1;
    chk("fo_if_gnt_c0", 64'(bus.if_gnt), 1);
    chk("fo_mem_addr", 64'(bus.mem_addr), 32'h10);
    chk("fo_mem_we", 64'(bus.mem_we), 0);
    chk("fo_d_gnt", 64'(bus.d_gnt), 0);
    next();
    drop_reqs();
    #1;
    chk("fo_c1_rvalid", 64'(bus.if_rvalid), 0);
    chk("fo_c1_mem_req", 64'(bus.mem_req), 0);
    next();
    #1;
    chk("fo_c2_if_rvalid", 64'(bus.if_rvalid), 1);
    chk("fo_c2_if_rdata", 64'(bus.if_rdata), 32'h00500093);
    chk("fo_c2_d_rvalid", 64'(bus.d_rvalid), 0);

    // Conflict: data load wins, fetch follows after one idle memory cycle.
    next();
    rv_gap = 1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h20;
    bus.d_req   = 1'b1;
    bus.d_addr  = 32'h40;
    expect_rsp(1'b1, 32'h12345678);
    expect_rsp(1'b0, 32'h00A00113);
    #1;
    chk("cf_d_gnt", 64'(bus.d_gnt), 1);
    chk("cf_if_gnt_c0", 64'(bus.if_gnt), 0);
    chk("cf_mem_we", 64'(bus.mem_we), 0);
    chk("cf_mem_addr", 64'(bus.mem_addr), 32'h40);
    next();
    bus.d_req = 1'b0;
    #1;
    chk("cf_c1_d_rvalid", 64'(bus.d_rvalid), 1);
    chk("cf_c1_if_gnt", 64'(bus.if_gnt), 0);
    chk("cf_c1_mem_req", 64'(bus.mem_req), 0);
    next();
    #1;
    chk("cf_c2_if_gnt", 64'(bus.if_gnt), 1);
    chk("cf_c2_mem_addr", 64'(bus.mem_addr), 32'h20);
    next();
    drop_reqs();
    #1;
    chk("cf_c3_if_rvalid", 64'(bus.if_rvalid), 1);

    // Starvation limiter: four data grants then one fetch grant, repeating.
    next();
    gnt_log.delete();
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) expect_rsp(1'b0, 32'h00A00113);
      else            expect_rsp(1'b1, 32'h12345678);
    end
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h20;
    bus.d_req   = 1'b1;
    bus.d_addr  = 32'h40;
    for (int c = 0; c < 19; c++) next();
    next();
    drop_reqs();
    #3;
    chk("sv_grant_count", 64'(gnt_log.size()), 10);
    for (int i = 0; i < 10 && i < gnt_log.size(); i++)
      chk($sformatf("sv_grant_%0d_is_d", i), 64'(gnt_log[i]), 64'(i % 5 != 4));

    // Grant stall on a store while a fetch arrives behind it.
    next();
    gnt_en      = 1'b0;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h80;
    bus.d_wdata = 32'hDEADBEEF;
    expect_rsp(1'b1, 32'h0);
    #1;
    chk("gs_c0_mem_we", 64'(bus.mem_we), 1);
    chk("gs_c0_d_gnt", 64'(bus.d_gnt), 0);
    for (int c = 1; c < 3; c++) begin
      next();
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h10;
      #1;
      chk($sformatf("gs_c%0d_mem_addr", c), 64'(bus.mem_addr), 32'h80);
      chk($sformatf("gs_c%0d_mem_wdata", c), 64'(bus.mem_wdata), 32'hDEADBEEF);
      chk($sformatf("gs_c%0d_gnts", c), 64'({bus.if_gnt, bus.d_gnt}), 0);
    end
    next();
    gnt_en = 1'b1;
    #1;
    chk("gs_c3_d_gnt", 64'(bus.d_gnt), 1);
    chk("gs_c3_if_gnt", 64'(bus.if_gnt), 0);
    next();
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    #1;
    chk("gs_c4_d_rvalid", 64'(bus.d_rvalid), 1);
    chk("gs_c4_if_gnt", 64'(bus.if_gnt), 0);
    next();
    expect_rsp(1'b0, 32'h00500093);
    #1;
    chk("gs_c5_if_gnt", 64'(bus.if_gnt), 1);
    next();
    drop_reqs();
    next();
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h80;
    expect_rsp(1'b1, 32'hDEADBEEF);
    #1;
    chk("gs_readback_gnt", 64'(bus.d_gnt), 1);
    next();
    drop_reqs();

    // Reset while waiting for rvalid: the late response must be dropped.
    next();
    rv_gap     = 3;
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h40;
    #1;
    chk("rw_d_gnt", 64'(bus.d_gnt), 1);
    next();
    drop_reqs();
    rst = 1'b1;
    #1;
    outs_zero("rw_in_rst");
    next();
    rst = 1'b0;
    next();
    #1;
    outs_zero("rw_late_rvalid");
    chk("rw_d_rdata", 64'(bus.d_rdata), 0);
    next();
    rv_gap      = 1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    expect_rsp(1'b0, 32'h00500093);
    #1;
    chk("rw_idle_if_gnt", 64'(bus.if_gnt), 1);
    next();
    drop_reqs();

    // Spurious rvalid in IDLE and in REQ.
    next();
    spur_rvalid = 1'b1;
    spur_rdata  = 32'hCAFEF00D;
    #1;
    outs_zero("sp_idle");
    next();
    spur_rvalid = 1'b0;
    gnt_en      = 1'b0;
    bus.d_req   = 1'b1;
    bus.d_addr  = 32'h40;
    next();
    spur_rvalid = 1'b1;
    #1;
    chk("sp_req_d_rvalid", 64'(bus.d_rvalid), 0);
    chk("sp_req_mem_req", 64'(bus.mem_req), 1);
    chk("sp_req_d_gnt", 64'(bus.d_gnt), 0);
    next();
    spur_rvalid = 1'b0;
    gnt_en      = 1'b1;
    expect_rsp(1'b1, 32'h12345678);
    #1;
    chk("sp_late_d_gnt", 64'(bus.d_gnt), 1);
    next();
    drop_reqs();

`ifdef ARB_PERF_CNT_EN
    next();
    rst = 1'b1;
    next();
    rst = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h20;
    bus.d_req   = 1'b1;
    bus.d_addr  = 32'h40;
    for (int i = 0; i < 3; i++) expect_rsp(1'b1, 32'h12345678);
    for (int c = 0; c < 5; c++) next();
    next();
    drop_reqs();
    #1;
    chk("perf_conflicts", 64'(perf_conflicts), 3);
    chk("perf_d_grants", 64'(perf_d_grants), 3);
    chk("perf_if_grants", 64'(perf_if_grants), 0);
`endif

    next();
    next();
    chk("sb_drained", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
